// File: rtl/val_ready_rr_arbiter.sv
// rtl/val_ready_rr_arbiter.sv - round-robin valid/ready arbiter with burst ownership and a registered output stage
//
// Shares one valid/ready output channel between NREQ valid/ready requesters.
// A requester that wins arbitration keeps the channel for up to MAXBURST
// consecutive beats, then the grant rotates to the next requester.
//
// Ports:
//   clk_i        rising-edge clock
//   rst_ni       asynchronous active-low reset
//   req_valid_i  per-requester valid
//   req_data_i   requester k data at bits [k*DW +: DW]
//   req_ready_o  per-requester ready, at most one bit high
//   valid_o      output beat valid
//   data_o       output beat data
//   ready_i      downstream ready
//   grant_id_o   source index of the beat held in data_o
//   busy_o       high while a requester owns the channel (state OWN)
module val_ready_rr_arbiter #(
    parameter int DW       = 8,
    parameter int NREQ     = 4,
    parameter int MAXBURST = 2
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic [NREQ-1:0]         req_valid_i,
    input  logic [NREQ*DW-1:0]      req_data_i,
    output logic [NREQ-1:0]         req_ready_o,
    output logic                    valid_o,
    output logic [DW-1:0]           data_o,
    input  logic                    ready_i,
    output logic [$clog2(NREQ)-1:0] grant_id_o,
    output logic                    busy_o
);

    localparam int IW = $clog2(NREQ);

    typedef enum logic {
        ARB = 1'b0,
        OWN = 1'b1
    } state_t;

    state_t          state;
    logic [IW-1:0]   ptr;
    logic [IW-1:0]   owner;
    logic [7:0]      cnt;

    logic            load_en;
    logic            keep;
    logic [IW-1:0]   start;
    logic            found;
    logic [IW-1:0]   winner;
    logic            gnt_valid;
    logic [IW-1:0]   gnt_id;
    logic            xfer;
    logic [DW-1:0]   beat;
    logic            burst_done;

    // Index base+off modulo NREQ; NREQ need not be a power of two.
    function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= NREQ) begin
            s = s - NREQ;
        end
        return IW'(s);
    endfunction

    always_comb begin
        load_en = !valid_o || ready_i;

        // The owner keeps the channel only while it still has data; otherwise
        // arbitration restarts just past the owner in the same cycle.
        keep  = (state == OWN) && req_valid_i[owner];
        start = (state == OWN) ? wrap_add(owner, 1) : ptr;

        // Scan from the farthest offset down so the closest valid one wins.
        found  = 1'b0;
        winner = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req_valid_i[wrap_add(start, i)]) begin
                found  = 1'b1;
                winner = wrap_add(start, i);
            end
        end

        gnt_valid = keep || found;
        gnt_id    = keep ? owner : winner;
        xfer      = load_en && gnt_valid;

        req_ready_o = '0;
        if (rst_ni && xfer) begin
            req_ready_o[gnt_id] = 1'b1;
        end

        beat       = req_data_i[int'(gnt_id)*DW +: DW];
        burst_done = (({1'b0, cnt} + 9'd1) == 9'(MAXBURST));
    end

    assign busy_o = (state == OWN);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_o    <= 1'b0;
            data_o     <= '0;
            grant_id_o <= '0;
            state      <= ARB;
            ptr        <= '0;
            owner      <= '0;
            cnt        <= '0;
        end else if (load_en) begin
            // Output stage: drain and reload on the same edge.
            if (xfer) begin
                valid_o    <= 1'b1;
                data_o     <= beat;
                grant_id_o <= gnt_id;
            end else begin
                valid_o    <= 1'b0;
            end

            if (keep) begin
                if (burst_done) begin
                    state <= ARB;
                    ptr   <= wrap_add(owner, 1);
                    cnt   <= '0;
                end else begin
                    cnt   <= cnt + 8'd1;
                end
            end else begin
                if (state == OWN) begin
                    ptr <= wrap_add(owner, 1);
                end
                if (xfer) begin
                    if (MAXBURST == 1) begin
                        state <= ARB;
                        ptr   <= wrap_add(winner, 1);
                        cnt   <= '0;
                    end else begin
                        state <= OWN;
                        owner <= winner;
                        cnt   <= 8'd1;
                    end
                end else begin
                    state <= ARB;
                    cnt   <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_val_ready_rr_arbiter.sv
// tb/tb_val_ready_rr_arbiter.sv - scoreboard bench for val_ready_rr_arbiter
module tb_val_ready_rr_arbiter;

    localparam int DW   = 8;
    localparam int NREQ = 4;

    logic              clk = 1'b0;
    logic              rst_ni;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_valid1;
    logic [NREQ*DW-1:0] req_data;
    logic              ready;
    logic              ready1;

    logic [NREQ-1:0]   req_ready;
    logic              valid_o;
    logic [DW-1:0]     data_o;
    logic [1:0]        grant_id;
    logic              busy;

    logic [NREQ-1:0]   req_ready1;
    logic              valid1;
    logic [DW-1:0]     data1;
    logic [1:0]        grant_id1;
    logic              busy1;

    int vectors = 0;
    int errors  = 0;

    logic [15:0] exp_q0[$];
    logic [15:0] exp_q1[$];

    always #5 clk = ~clk;

    val_ready_rr_arbiter #(.DW(DW), .NREQ(NREQ), .MAXBURST(2)) u_dut (
        .clk_i      (clk),
        .rst_ni     (rst_ni),
        .req_valid_i(req_valid),
        .req_data_i (req_data),
        .req_ready_o(req_ready),
        .valid_o    (valid_o),
        .data_o     (data_o),
        .ready_i    (ready),
        .grant_id_o (grant_id),
        .busy_o     (busy)
    );

    val_ready_rr_arbiter #(.DW(DW), .NREQ(NREQ), .MAXBURST(1)) u_dut1 (
        .clk_i      (clk),
        .rst_ni     (rst_ni),
        .req_valid_i(req_valid1),
        .req_data_i (req_data),
        .req_ready_o(req_ready1),
        .valid_o    (valid1),
        .data_o     (data1),
        .ready_i    (ready1),
        .grant_id_o (grant_id1),
        .busy_o     (busy1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_data(input int k, input logic [7:0] v);
        req_data[k*DW +: DW] = v;
    endtask

    task automatic push0(input logic [1:0] id, input logic [7:0] d);
        exp_q0.push_back({6'd0, id, d});
    endtask

    task automatic push1(input logic [1:0] id, input logic [7:0] d);
        exp_q1.push_back({6'd0, id, d});
    endtask

    task automatic apply_reset();
        rst_ni     = 1'b0;
        req_valid  = '0;
        req_valid1 = '0;
        step();
        step();
        rst_ni = 1'b1;
    endtask

    // Monitors: pop one expected beat per downstream handshake.
    always @(negedge clk) begin
        if (rst_ni) begin
            chk("onehot_ready0", 32'($countones(req_ready) <= 1), 32'd1);
            if (valid_o && ready) begin
                vectors++;
                if (exp_q0.size() == 0) begin
                    errors++;
                    $display("FAIL beat0: unexpected beat id %0d data %0h", grant_id, data_o);
                end else begin
                    logic [15:0] e;
                    e = exp_q0.pop_front();
                    if ({6'd0, grant_id, data_o} !== e) begin
                        errors++;
                        $display("FAIL beat0: got id %0d data %0h expected id %0d data %0h",
                                 grant_id, data_o, e[9:8], e[7:0]);
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst_ni) begin
            chk("onehot_ready1", 32'($countones(req_ready1) <= 1), 32'd1);
            if (valid1 && ready1) begin
                vectors++;
                if (exp_q1.size() == 0) begin
                    errors++;
                    $display("FAIL beat1: unexpected beat id %0d data %0h", grant_id1, data1);
                end else begin
                    logic [15:0] e;
                    e = exp_q1.pop_front();
                    if ({6'd0, grant_id1, data1} !== e) begin
                        errors++;
                        $display("FAIL beat1: got id %0d data %0h expected id %0d data %0h",
                                 grant_id1, data1, e[9:8], e[7:0]);
                    end
                end
            end
        end
    end

    initial begin
        int fair_ids[10];
        int budget;
        fair_ids = '{0, 0, 1, 1, 2, 2, 3, 3, 0, 0};
        rst_ni     = 1'b0;
        req_valid  = '0;
        req_valid1 = '0;
        req_data   = '0;
        ready      = 1'b1;
        ready1     = 1'b1;

        apply_reset();
        chk("reset_valid", 32'(valid_o), 32'd0);
        chk("reset_data", 32'(data_o), 32'd0);
        chk("reset_gid", 32'(grant_id), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);

        // Single requester, two beats.
        push0(2'd2, 8'h05);
        push0(2'd2, 8'h0A);
        set_data(2, 8'h05);
        req_valid = 4'b0100;
        step();
        chk("single_lat_valid", 32'(valid_o), 32'd1);
        chk("single_lat_data", 32'(data_o), 32'h05);
        chk("single_lat_gid", 32'(grant_id), 32'd2);
        set_data(2, 8'h0A);
        step();
        chk("single_b2_data", 32'(data_o), 32'h0A);
        req_valid = '0;
        step();
        chk("single_idle", 32'(valid_o), 32'd0);

        // Fairness: all valid, two-beat bursts in rotation.
        apply_reset();
        for (int k = 0; k < NREQ; k++) set_data(k, 8'(8'h10 + k));
        for (int i = 0; i < 10; i++) push0(2'(fair_ids[i]), 8'(8'h10 + fair_ids[i]));
        req_valid = 4'b1111;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("fair_valid", 32'(valid_o), 32'd1);
            chk("fair_busy", 32'(busy), 32'((i % 2) == 0));
        end
        req_valid = '0;
        step();
        chk("fair_idle", 32'(valid_o), 32'd0);

        // Asynchronous reset while a beat is held.
        apply_reset();
        set_data(0, 8'h05);
        req_valid = 4'b0001;
        ready = 1'b0;
        step();
        chk("rst_pre_valid", 32'(valid_o), 32'd1);
        chk("rst_pre_data", 32'(data_o), 32'h05);
        #2;
        rst_ni = 1'b0;
        #1;
        chk("rst_async_valid", 32'(valid_o), 32'd0);
        chk("rst_async_data", 32'(data_o), 32'd0);
        chk("rst_async_ready", 32'(req_ready), 32'd0);
        step();
        step();
        rst_ni = 1'b1;
        req_valid = '0;
        ready = 1'b1;
        step();
        chk("rst_post_valid", 32'(valid_o), 32'd0);
        step();
        chk("rst_post_valid2", 32'(valid_o), 32'd0);

        // Backpressure: held beat stable, then drain and load on one edge.
        apply_reset();
        push0(2'd0, 8'h05);
        push0(2'd1, 8'h21);
        set_data(0, 8'h05);
        req_valid = 4'b0001;
        ready = 1'b1;
        step();
        ready = 1'b0;
        req_valid = 4'b0010;
        set_data(1, 8'h21);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bp_ready", 32'(req_ready), 32'd0);
            chk("bp_data", 32'(data_o), 32'h05);
            chk("bp_gid", 32'(grant_id), 32'd0);
            chk("bp_valid", 32'(valid_o), 32'd1);
            step();
        end
        ready = 1'b1;
        #1;
        chk("bp_release_ready", 32'(req_ready), 32'b0010);
        step();
        chk("bp_next_data", 32'(data_o), 32'h21);
        chk("bp_next_gid", 32'(grant_id), 32'd1);
        req_valid = '0;
        step();
        chk("bp_idle", 32'(valid_o), 32'd0);

        // Early release by req0, then pointer lands past req1.
        apply_reset();
        push0(2'd0, 8'h30);
        push0(2'd1, 8'h41);
        push0(2'd1, 8'h42);
        push0(2'd3, 8'h63);
        set_data(0, 8'h30);
        set_data(1, 8'h41);
        req_valid = 4'b0011;
        step();
        chk("er_b0_gid", 32'(grant_id), 32'd0);
        req_valid = 4'b0010;
        #1;
        chk("er_release_ready", 32'(req_ready), 32'b0010);
        step();
        chk("er_b1_valid", 32'(valid_o), 32'd1);
        chk("er_b1_gid", 32'(grant_id), 32'd1);
        set_data(1, 8'h42);
        step();
        chk("er_b2_gid", 32'(grant_id), 32'd1);
        req_valid = 4'b1001;
        set_data(0, 8'h60);
        set_data(3, 8'h63);
        #1;
        chk("er_ptr_ready", 32'(req_ready), 32'b1000);
        step();
        chk("er_b3_gid", 32'(grant_id), 32'd3);
        req_valid = '0;
        step();
        chk("er_idle", 32'(valid_o), 32'd0);

        // MAXBURST=1 instance: alternating grants under toggling ready.
        apply_reset();
        push1(2'd1, 8'h51);
        push1(2'd3, 8'h53);
        push1(2'd1, 8'h51);
        set_data(1, 8'h51);
        set_data(3, 8'h53);
        req_valid1 = 4'b1010;
        ready1 = 1'b1;
        step();
        ready1 = 1'b0;
        #1;
        chk("mb1_hold_data", 32'(data1), 32'h51);
        chk("mb1_hold_gid", 32'(grant_id1), 32'd1);
        chk("mb1_hold_ready", 32'(req_ready1), 32'd0);
        step();
        chk("mb1_held_data", 32'(data1), 32'h51);
        chk("mb1_held_valid", 32'(valid1), 32'd1);
        ready1 = 1'b1;
        step();
        chk("mb1_b2_gid", 32'(grant_id1), 32'd3);
        chk("mb1_b2_data", 32'(data1), 32'h53);
        step();
        chk("mb1_b3_gid", 32'(grant_id1), 32'd1);
        req_valid1 = '0;
        step();
        chk("mb1_idle", 32'(valid1), 32'd0);

        budget = 0;
        while ((exp_q0.size() != 0 || exp_q1.size() != 0) && budget < 20) begin
            step();
            budget++;
        end
        chk("q0_empty", 32'(exp_q0.size()), 32'd0);
        chk("q1_empty", 32'(exp_q1.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
